mips_dmem_arbiter: RTL and testbench
====================================

Name: mips_dmem_arbiter

Overview:
- Shares the single-port synchronous data memory of MIPS_System between two requesters: the CPU load/store port and a debug/DMA port. The debug port is driven by the board SW/BUTTON logic for memory inspect/poke.
- Sits between the datapath memory stage and the data RAM. When the CPU loses arbitration, the arbiter stalls it.
- Grants one access per cycle, with selectable fixed-CPU or round-robin priority, a starvation bound for the debug port, and a debug burst lock.

Parameters:
- AW, 6, word-address width of the data RAM (64 words).
- DW, 32, data width.
- CPU_PRIORITY, 1: 1 = CPU wins contention (subject to MAX_WAIT); 0 = round-robin.
- MAX_WAIT, 4: debug-denied cycles after which debug wins the next contention (CPU_PRIORITY=1 only); range 1..15.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU write data.
- cpu_stall  out  1  high when cpu_req=1 and not granted this cycle.
- cpu_rvalid  out  1  CPU read data valid (registered).
- cpu_rdata  out  DW  CPU read data.
- dbg_req  in  1  debug request; held until dbg_gnt.
- dbg_we  in  1  debug write enable.
- dbg_lock  in  1  keep ownership after the current grant (burst).
- dbg_addr  in  AW  debug word address.
- dbg_wdata  in  DW  debug write data.
- dbg_gnt  out  1  debug access accepted this cycle.
- dbg_rvalid  out  1  debug read data valid (registered).
- dbg_rdata  out  DW  debug read data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid one cycle after mem_en with mem_we=0.

Behaviour:
- Grant decision is combinational from the current requests and registered state. The winner's signals drive mem_* in the same cycle. cpu_gnt is internal: cpu_stall = cpu_req & ~cpu_gnt. dbg_gnt is asserted in the grant cycle.
- mem_en = cpu_gnt | dbg_gnt. When there is no grant, mem_we=0 and mem_addr/mem_wdata=0.
- Registered state: last_owner (0=CPU, 1=DBG), locked, wait_cnt[3:0], rd_owner[1:0] (read-pending flags).
- Contention rules (cpu_req & dbg_req):
  - locked=1: debug wins.
  - CPU_PRIORITY=1: debug wins if wait_cnt >= MAX_WAIT, else CPU wins.
  - CPU_PRIORITY=0: the requester that did not win last time wins (last_owner toggles).
- A single requester always wins unless locked=1 and that requester is the CPU. The CPU is stalled while locked, even if dbg_req=0.
- Lock: locked<=1 on a debug grant with dbg_lock=1; locked<=0 whenever dbg_lock=0.
- wait_cnt: +1 each cycle dbg_req & ~dbg_gnt, saturating at 15; cleared on dbg_gnt.
- Read latency is 1 cycle. A granted read sets rd_owner. Next cycle, the owner's rvalid=1 and its rdata = mem_rdata. The other port's rdata holds 0 and its rvalid=0. Writes produce no rvalid.
- Back-to-back reads by alternating owners: each rvalid goes only to its own port. There is at most one rvalid per cycle.
- Reset (reset=0 at a clock edge) sets all registers to 0: last_owner=CPU, locked=0, wait_cnt=0, rvalid=0. Any in-flight read response is dropped.
- During reset, combinational outputs still follow the grant logic but mem_en is forced 0, so no RAM write occurs while reset=0.

Decomposition:
- Shared package/include: owner encoding constants OWN_CPU=1'b0, OWN_DBG=1'b1; default AW/DW.
- One natural sub-module: mips_rr_pick2 (two-requester pick with priority mode, lock and wait-bound inputs; combinational). The top holds the state registers and read-return steering.

Test Plan:
- Default params. CPU read addr 5 alone, RAM[5]=32'h1234 -> cpu_stall=0, mem_en=1, mem_addr=5; next cycle cpu_rvalid=1, cpu_rdata=32'h1234, dbg_rvalid=0.
- CPU_PRIORITY=1, MAX_WAIT=4. cpu_req and dbg_req held high continuously -> CPU granted 4 cycles, dbg_gnt in the 5th cycle (cpu_stall=1 that cycle), wait_cnt cleared, pattern repeats.
- CPU_PRIORITY=0, both requesting reads (CPU addr 1, debug addr 2) -> grants alternate every cycle. rvalids alternate, with each port's rdata matching its own address.
- Debug writes 32'hDEAD_BEEF to addr 3 then addr 4 with dbg_lock=1, CPU requesting throughout -> both debug writes granted consecutively. cpu_stall=1 until the cycle after dbg_lock drops; then CPU granted.
- Debug read granted, reset=0 asserted on the next edge -> dbg_rvalid stays 0, locked=0, wait_cnt=0, no mem write during reset.
- Simultaneous cpu_req=0 and dbg_req=0 -> mem_en=0, cpu_stall=0, dbg_gnt=0, state unchanged.

Source files
------------

// File: rtl/mips_dmem_arbiter_pkg.sv
// Shared definitions for the MIPS_System data-memory arbiter.
// These are the owner encodings, the read-return flag positions, the default
// RAM geometry and the saturating wait-counter helper.
package mips_dmem_arbiter_pkg;

    localparam int DEFAULT_AW = 6;
    localparam int DEFAULT_DW = 32;

    // Who owned the most recent RAM grant
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    // Bit positions inside the read-pending flags
    localparam int RD_CPU = 0;
    localparam int RD_DBG = 1;

    localparam logic [3:0] WAIT_SAT = 4'd15;

    // Priority modes for the two-requester pick
    typedef enum logic {
        PRIO_ROUND_ROBIN = 1'b0,
        PRIO_FIXED_CPU   = 1'b1
    } prio_mode_e;

    // A denied debug request ages the counter, and a debug grant clears it.
    // The counter stops at WAIT_SAT so that a long stall cannot wrap it back
    // to zero.
    function automatic logic [3:0] waitNext(input logic [3:0] cnt,
                                            input logic       dbgReq,
                                            input logic       dbgGnt);
        logic [3:0] nxt;
        nxt = cnt;
        if (dbgGnt) begin
            nxt = 4'd0;
        end else if (dbgReq && (cnt != WAIT_SAT)) begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mips_rr_pick2.sv
// Combinational two-way pick between the CPU port and the debug port.
// A debug burst lock overrides everything. Otherwise contention is settled
// by fixed CPU priority with a debug starvation bound, or by alternating
// owners.
module mips_rr_pick2
    import mips_dmem_arbiter_pkg::*;
#(
    parameter prio_mode_e PRIO_MODE = PRIO_FIXED_CPU
) (
    input  logic cpuReq_i,
    input  logic dbgReq_i,
    input  logic locked_i,
    input  logic waitExpired_i,
    input  logic lastOwner_i,
    output logic cpuGnt_o,
    output logic dbgGnt_o
);

    // Choose at most one winner from the live requests and the arbiter state
    always_comb begin
        cpuGnt_o = 1'b0;
        dbgGnt_o = 1'b0;
        if (locked_i) begin
            dbgGnt_o = dbgReq_i;
        end else if (cpuReq_i && dbgReq_i) begin
            if (PRIO_MODE == PRIO_FIXED_CPU) begin
                dbgGnt_o = waitExpired_i;
            end else begin
                dbgGnt_o = (lastOwner_i == OWN_CPU);
            end
            cpuGnt_o = ~dbgGnt_o;
        end else begin
            cpuGnt_o = cpuReq_i;
            dbgGnt_o = dbgReq_i;
        end
    end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Data-memory arbiter for MIPS_System.
// It shares the single-port synchronous data RAM between the CPU load/store
// port and the board debug/DMA port, and it stalls the CPU whenever it loses.
// Read data comes back one cycle after the grant and is steered only to the
// port that issued the read.
module mips_dmem_arbiter
    import mips_dmem_arbiter_pkg::*;
#(
    parameter int AW           = DEFAULT_AW,
    parameter int DW           = DEFAULT_DW,
    parameter int CPU_PRIORITY = 1,
    parameter int MAX_WAIT     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam prio_mode_e PRIO_MODE  = (CPU_PRIORITY != 0) ? PRIO_FIXED_CPU : PRIO_ROUND_ROBIN;
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic       lastOwner_q, lastOwner_d;
    logic       locked_q,    locked_d;
    logic [3:0] waitCnt_q,   waitCnt_d;
    logic [1:0] rdOwner_q,   rdOwner_d;

    logic cpuGnt;
    logic dbgGnt;
    logic waitExpired;

    assign waitExpired = (waitCnt_q >= MAX_WAIT_C);

    mips_rr_pick2 #(
        .PRIO_MODE(PRIO_MODE)
    ) u_pick (
        .cpuReq_i     (cpu_req),
        .dbgReq_i     (dbg_req),
        .locked_i     (locked_q),
        .waitExpired_i(waitExpired),
        .lastOwner_i  (lastOwner_q),
        .cpuGnt_o     (cpuGnt),
        .dbgGnt_o     (dbgGnt)
    );

    // Drive the RAM from the winner. While reset is low the RAM is never enabled or written.
    always_comb begin
        cpu_stall = cpu_req & ~cpuGnt;
        dbg_gnt   = dbgGnt;
        mem_en    = (cpuGnt | dbgGnt) & reset;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpuGnt) begin
            mem_we    = cpu_we & reset;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbgGnt) begin
            mem_we    = dbg_we & reset;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Work out the owner history, burst lock, debug aging and read-pending flags for the next cycle
    always_comb begin
        lastOwner_d = lastOwner_q;
        if (cpuGnt) begin
            lastOwner_d = OWN_CPU;
        end else if (dbgGnt) begin
            lastOwner_d = OWN_DBG;
        end

        locked_d = locked_q;
        if (!dbg_lock) begin
            locked_d = 1'b0;
        end else if (dbgGnt) begin
            locked_d = 1'b1;
        end

        waitCnt_d = waitNext(waitCnt_q, dbg_req, dbgGnt);

        rdOwner_d         = 2'b00;
        rdOwner_d[RD_CPU] = cpuGnt & ~cpu_we;
        rdOwner_d[RD_DBG] = dbgGnt & ~dbg_we;
    end

    // Arbiter state registers. Reset also discards any read response still in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lastOwner_q <= OWN_CPU;
            locked_q    <= 1'b0;
            waitCnt_q   <= 4'd0;
            rdOwner_q   <= 2'b00;
        end else begin
            lastOwner_q <= lastOwner_d;
            locked_q    <= locked_d;
            waitCnt_q   <= waitCnt_d;
            rdOwner_q   <= rdOwner_d;
        end
    end

    // Send the RAM read data only to the port that issued the read. The other port sees zero.
    always_comb begin
        cpu_rvalid = rdOwner_q[RD_CPU];
        dbg_rvalid = rdOwner_q[RD_DBG];
        cpu_rdata  = rdOwner_q[RD_CPU] ? mem_rdata : '0;
        dbg_rdata  = rdOwner_q[RD_DBG] ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Self-checking bench for mips_dmem_arbiter.
// Instance 0 uses fixed CPU priority and instance 1 uses round-robin. Both
// see the same stimulus, and each has its own RAM and its own reference model.
module tb_mips_dmem_arbiter;

    localparam int AW       = 6;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic          clk;
    logic          reset;
    logic          cpuReq, cpuWe, dbgReq, dbgWe, dbgLock;
    logic [AW-1:0] cpuAddr, dbgAddr;
    logic [DW-1:0] cpuWdata, dbgWdata;

    logic          cpuStall[2], cpuRvalid[2], dbgGnt[2], dbgRvalid[2], memEn[2], memWe[2];
    logic [DW-1:0] cpuRdata[2], dbgRdata[2], memWdata[2], memRdata[2];
    logic [AW-1:0] memAddr[2];

    int assertCount = 0;
    int failCount   = 0;
    int cycleNo     = 0;

    // Bench RAMs. A word never written reads back its initVal.
    logic [DW-1:0] ram[2][64];
    bit            ramWr[2][64];

    // Reference model state, one set per instance (0 = fixed priority, 1 = round-robin)
    bit            mLast[2], mLocked[2], mPC[2], mPD[2];
    int            mWait[2];
    logic [DW-1:0] mDC[2], mDD[2];
    logic [DW-1:0] refMem[2][64];
    bit            refWr[2][64];
    bit            pCg[2], pDg[2];

    typedef struct {
        logic          cReq, cWe;
        logic [AW-1:0] cAddr;
        logic [DW-1:0] cWdata;
        logic          dReq, dWe, dLock;
        logic [AW-1:0] dAddr;
        logic [DW-1:0] dWdata;
        logic          eStall, eGnt, eEn;
        logic [AW-1:0] eAddr;
        logic          eCRv;
        logic [DW-1:0] eCRd;
        logic          eDRv;
    } vec_t;

    vec_t vecs[9];

    mips_dmem_arbiter #(.AW(AW), .DW(DW), .CPU_PRIORITY(1), .MAX_WAIT(MAX_WAIT)) dutPrio (
        .clk(clk), .reset(reset),
        .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
        .cpu_stall(cpuStall[0]), .cpu_rvalid(cpuRvalid[0]), .cpu_rdata(cpuRdata[0]),
        .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_lock(dbgLock), .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata),
        .dbg_gnt(dbgGnt[0]), .dbg_rvalid(dbgRvalid[0]), .dbg_rdata(dbgRdata[0]),
        .mem_en(memEn[0]), .mem_we(memWe[0]), .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]),
        .mem_rdata(memRdata[0])
    );

    mips_dmem_arbiter #(.AW(AW), .DW(DW), .CPU_PRIORITY(0), .MAX_WAIT(MAX_WAIT)) dutRr (
        .clk(clk), .reset(reset),
        .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
        .cpu_stall(cpuStall[1]), .cpu_rvalid(cpuRvalid[1]), .cpu_rdata(cpuRdata[1]),
        .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_lock(dbgLock), .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata),
        .dbg_gnt(dbgGnt[1]), .dbg_rvalid(dbgRvalid[1]), .dbg_rdata(dbgRdata[1]),
        .mem_en(memEn[1]), .mem_we(memWe[1]), .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]),
        .mem_rdata(memRdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] initVal(input int a);
        if (a == 5) return 32'h0000_1234;
        return 32'hA5A5_0000 + 32'(a) * 32'h0000_0101;
    endfunction

    // Synchronous single-port RAM behind each arbiter
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (memEn[m]) begin
                if (memWe[m]) begin
                    ram[m][memAddr[m]]   <= memWdata[m];
                    ramWr[m][memAddr[m]] <= 1'b1;
                end else begin
                    memRdata[m] <= ramWr[m][memAddr[m]] ? ram[m][memAddr[m]] : initVal(int'(memAddr[m]));
                end
            end
        end
    end

    function automatic logic [DW-1:0] refRead(input int m, input int a);
        return refWr[m][a] ? refMem[m][a] : initVal(a);
    endfunction

    // Apply the arbitration rules to the current requests and the model state
    function automatic void predict(input int m, output bit cg, output bit dg);
        cg = 1'b0;
        dg = 1'b0;
        if (mLocked[m]) begin
            dg = dbgReq;
        end else if (cpuReq && dbgReq) begin
            if (m == 0) dg = (mWait[m] >= MAX_WAIT);
            else        dg = (mLast[m] == 1'b0);
            cg = !dg;
        end else begin
            cg = cpuReq;
            dg = dbgReq;
        end
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cycleNo, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                                 input logic dr, input logic dw, input logic dl, input logic [AW-1:0] da,
                                 input logic [DW-1:0] dd);
        cpuReq = cr; cpuWe = cw; cpuAddr = ca; cpuWdata = cd;
        dbgReq = dr; dbgWe = dw; dbgLock = dl; dbgAddr = da; dbgWdata = dd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Compare both instances against the reference model. Sampled at the falling edge.
    task automatic checkOutput();
        bit cg, dg, en;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic ew;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            predict(m, cg, dg);
            pCg[m] = cg;
            pDg[m] = dg;
            en = (cg | dg) & reset;
            ea = cg ? cpuAddr : (dg ? dbgAddr : '0);
            ed = cg ? cpuWdata : (dg ? dbgWdata : '0);
            ew = en & (cg ? cpuWe : (dg ? dbgWe : 1'b0));
            check($sformatf("i%0d cpu_stall", m), cpuStall[m], cpuReq & ~cg);
            check($sformatf("i%0d dbg_gnt", m), dbgGnt[m], dg);
            check($sformatf("i%0d mem_en", m), memEn[m], en);
            check($sformatf("i%0d mem_we", m), memWe[m], ew);
            check($sformatf("i%0d mem_addr", m), memAddr[m], ea);
            check($sformatf("i%0d mem_wdata", m), memWdata[m], ed);
            check($sformatf("i%0d cpu_rvalid", m), cpuRvalid[m], mPC[m]);
            check($sformatf("i%0d cpu_rdata", m), cpuRdata[m], mPC[m] ? mDC[m] : '0);
            check($sformatf("i%0d dbg_rvalid", m), dbgRvalid[m], mPD[m]);
            check($sformatf("i%0d dbg_rdata", m), dbgRdata[m], mPD[m] ? mDD[m] : '0);
        end
    endtask

    // Clock edge: update the reference models from what was predicted this cycle
    task automatic advance();
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!reset) begin
                mLast[m] = 1'b0; mLocked[m] = 1'b0; mWait[m] = 0; mPC[m] = 1'b0; mPD[m] = 1'b0;
            end else begin
                mPC[m] = pCg[m] && !cpuWe;
                mDC[m] = refRead(m, int'(cpuAddr));
                mPD[m] = pDg[m] && !dbgWe;
                mDD[m] = refRead(m, int'(dbgAddr));
                if (pCg[m] && cpuWe) begin refMem[m][cpuAddr] = cpuWdata; refWr[m][cpuAddr] = 1'b1; end
                if (pDg[m] && dbgWe) begin refMem[m][dbgAddr] = dbgWdata; refWr[m][dbgAddr] = 1'b1; end
                if (pCg[m]) mLast[m] = 1'b0;
                else if (pDg[m]) mLast[m] = 1'b1;
                if (!dbgLock) mLocked[m] = 1'b0;
                else if (pDg[m]) mLocked[m] = 1'b1;
                if (pDg[m]) mWait[m] = 0;
                else if (dbgReq) mWait[m] = (mWait[m] >= 15) ? 15 : mWait[m] + 1;
            end
        end
        cycleNo++;
        #1;
    endtask

    task automatic resetDut();
        reset = 1'b0;
        repeat (2) begin
            idle();
            checkOutput();
            advance();
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle();

        // Directed vectors for the fixed-priority instance, starting from reset state
        vecs[0] = '{1'b1, 1'b0, 6'd5, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 32'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'h1234, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 6'd7, 32'd0, 1'b1, 1'b0, 1'b0, 6'd9, 32'd0, 1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 32'd0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 6'd7, 32'd0, 1'b1, 1'b0, 1'b0, 6'd9, 32'd0, 1'b0, 1'b0, 1'b1, 6'd7, 1'b1, initVal(7), 1'b0};
        vecs[4] = '{1'b1, 1'b0, 6'd7, 32'd0, 1'b1, 1'b0, 1'b0, 6'd9, 32'd0, 1'b0, 1'b0, 1'b1, 6'd7, 1'b1, initVal(7), 1'b0};
        vecs[5] = '{1'b1, 1'b0, 6'd7, 32'd0, 1'b1, 1'b0, 1'b0, 6'd9, 32'd0, 1'b0, 1'b0, 1'b1, 6'd7, 1'b1, initVal(7), 1'b0};
        vecs[6] = '{1'b1, 1'b0, 6'd7, 32'd0, 1'b1, 1'b0, 1'b0, 6'd9, 32'd0, 1'b1, 1'b1, 1'b1, 6'd9, 1'b1, initVal(7), 1'b0};
        vecs[7] = '{1'b1, 1'b0, 6'd7, 32'd0, 1'b1, 1'b0, 1'b0, 6'd9, 32'd0, 1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 32'd0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, initVal(7), 1'b0};

        resetDut();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].cReq, vecs[i].cWe, vecs[i].cAddr, vecs[i].cWdata,
                          vecs[i].dReq, vecs[i].dWe, vecs[i].dLock, vecs[i].dAddr, vecs[i].dWdata);
            checkOutput();
            check($sformatf("vec%0d cpu_stall", i), cpuStall[0], vecs[i].eStall);
            check($sformatf("vec%0d dbg_gnt", i), dbgGnt[0], vecs[i].eGnt);
            check($sformatf("vec%0d mem_en", i), memEn[0], vecs[i].eEn);
            check($sformatf("vec%0d mem_addr", i), memAddr[0], vecs[i].eAddr);
            check($sformatf("vec%0d cpu_rvalid", i), cpuRvalid[0], vecs[i].eCRv);
            check($sformatf("vec%0d cpu_rdata", i), cpuRdata[0], vecs[i].eCRd);
            check($sformatf("vec%0d dbg_rvalid", i), dbgRvalid[0], vecs[i].eDRv);
            advance();
        end

        // Round-robin: with both ports reading, grants alternate and start with debug
        resetDut();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b0, 6'd1, '0, 1'b1, 1'b0, 1'b0, 6'd2, '0);
            checkOutput();
            check("rr dbg_gnt", dbgGnt[1], (k % 2) == 0);
            check("rr cpu_rvalid", cpuRvalid[1], (k >= 2) && ((k % 2) == 0));
            check("rr dbg_rvalid", dbgRvalid[1], (k % 2) == 1);
            if (k % 2 == 1) check("rr dbg_rdata", dbgRdata[1], initVal(2));
            if (k >= 2 && k % 2 == 0) check("rr cpu_rdata", cpuRdata[1], initVal(1));
            advance();
        end

        // Debug burst of two locked writes while the CPU keeps asking
        resetDut();
        for (int k = 0; k < 11; k++) begin
            if (k <= 4)       applyStimulus(1'b1, 1'b0, 6'd10, '0, 1'b1, 1'b1, 1'b1, 6'd3, 32'hDEAD_BEEF);
            else if (k == 5)  applyStimulus(1'b1, 1'b0, 6'd10, '0, 1'b1, 1'b1, 1'b1, 6'd4, 32'hDEAD_BEEF);
            else if (k <= 7)  applyStimulus(1'b1, 1'b0, 6'd10, '0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
            else if (k == 8)  applyStimulus(1'b1, 1'b0, 6'd3, '0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
            else if (k == 9)  applyStimulus(1'b1, 1'b0, 6'd4, '0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
            else              idle();
            checkOutput();
            if (k <= 5) check("burst dbg_gnt", dbgGnt[0], (k >= 4));
            if (k >= 4 && k <= 6) check("burst cpu_stall", cpuStall[0], 1'b1);
            if (k == 7) check("burst cpu regrant", cpuStall[0], 1'b0);
            if (k >= 9) check("burst readback", cpuRdata[0], 32'hDEAD_BEEF);
            advance();
        end

        // Reset in the middle of traffic clears wait_cnt and lock and drops the pending read
        resetDut();
        for (int k = 0; k < 12; k++) begin
            if (k <= 3)      applyStimulus(1'b1, 1'b0, 6'd7, '0, 1'b1, 1'b0, 1'b0, 6'd9, '0);
            else if (k == 4) applyStimulus(1'b0, 1'b0, 6'd0, '0, 1'b1, 1'b0, 1'b1, 6'd9, '0);
            else if (k == 5) applyStimulus(1'b0, 1'b0, 6'd0, '0, 1'b1, 1'b1, 1'b1, 6'd12, 32'h0BAD_0BAD);
            else if (k == 6) applyStimulus(1'b1, 1'b0, 6'd12, '0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
            else             applyStimulus(1'b1, 1'b0, 6'd7, '0, 1'b1, 1'b0, 1'b0, 6'd9, '0);
            if (k == 6) reset = 1'b1;
            checkOutput();
            if (k == 4) check("rst dbg_gnt", dbgGnt[0], 1'b1);
            if (k == 5) check("rst mem_en", memEn[0], 1'b0);
            if (k == 6) begin
                check("rst dbg_rvalid", dbgRvalid[0], 1'b0);
                check("rst unlocked", cpuStall[0], 1'b0);
            end
            if (k == 7) check("rst no write", cpuRdata[0], initVal(12));
            if (k >= 7) check("rst wait cleared", cpuStall[0], (k == 11));
            if (k == 3 || k == 4) reset = 1'b0;
            advance();
        end

        // Randomized traffic against the reference model, with occasional resets
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) != 0);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          6'($urandom_range(0, 63)), $urandom);
            checkOutput();
            advance();
        end
        reset = 1'b1;
        idle();
        checkOutput();
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
